// File: rtl/param_ins_cache.sv
// Direct-mapped instruction cache with a two-state (IDLE/MISS) line-refill FSM.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module param_ins_cache #(
  parameter int ADDR_W     = 8,
  parameter int INST_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rd_en,
  input  logic [ADDR_W-1:0]                         addr,
  input  logic                                      flush,
  output logic                                      rd_rdy,
  output logic [INST_W-1:0]                         inst,
  output logic                                      busy,
  output logic                                      mem_rd_en,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]      mem_addr,
  input  logic                                      mem_rd_rdy,
  input  logic [INST_W*LINE_WORDS-1:0]              mem_data,
  output logic                                      dbg_state
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                               hit_cnt,
  output logic [15:0]                               miss_cnt
`endif
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W  = INST_W * LINE_WORDS;
  localparam int LADDR_W = ADDR_W - OFF_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  // Handshake: a request is taken when rd_en=1 is sampled in IDLE with flush=0;
  // its answer is the single-cycle rd_rdy pulse. The memory side holds
  // mem_rd_en/mem_addr until a mem_rd_rdy pulse is sampled in MISS.

  logic [0:0]        r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];
  logic [OFF_W-1:0]  r_off;
  logic              r_rd_rdy;
  logic [INST_W-1:0] r_inst;
  logic              r_mem_rd_en;
  logic [LADDR_W-1:0] r_mem_addr;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [INST_W-1:0] w_hit_word;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic [INST_W-1:0] w_fill_word;
  logic              w_fill;
  logic              w_accept;

  assign w_off       = addr[OFF_W-1:0];
  assign w_idx       = addr[OFF_W +: IDX_W];
  assign w_tag       = addr[ADDR_W-1 -: TAG_W];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_word  = r_data[w_idx][INST_W*int'(w_off) +: INST_W];
  // The held line address doubles as the fill index/tag, so only the offset is latched.
  assign w_fill_idx  = r_mem_addr[IDX_W-1:0];
  assign w_fill_tag  = r_mem_addr[LADDR_W-1 -: TAG_W];
  assign w_fill_word = mem_data[INST_W*int'(r_off) +: INST_W];
  assign w_fill      = (r_state == S_MISS) && mem_rd_rdy;
  assign w_accept    = (r_state == S_IDLE) && rd_en && !flush;

  assign rd_rdy    = r_rd_rdy;
  assign inst      = r_inst;
  assign busy      = (r_state == S_MISS);
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_off       <= '0;
      r_rd_rdy    <= 1'b0;
      r_inst      <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_rd_rdy <= 1'b0;
      if (r_state == S_IDLE) begin
        if (flush) begin
          r_valid <= '0;
        end else if (rd_en) begin
          if (w_hit) begin
            r_inst   <= w_hit_word;
            r_rd_rdy <= 1'b1;
          end else begin
            r_state     <= S_MISS;
            r_off       <= w_off;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= addr[ADDR_W-1:OFF_W];
          end
        end
      end else begin
        if (flush) r_valid <= '0;
        // Placed after the flush clear so a coincident fill still leaves its line valid.
        if (mem_rd_rdy) begin
          r_valid[w_fill_idx] <= 1'b1;
          r_inst              <= w_fill_word;
          r_rd_rdy            <= 1'b1;
          r_mem_rd_en         <= 1'b0;
          r_state             <= S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (!w_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/param_ins_cache.md
PARAM_INS_CACHE -- requirements
Module: param_ins_cache

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction (word) address.
REQ-002 Parameter INST_W, default 16, instruction word width in bits.
REQ-003 Parameter LINE_WORDS, default 4, words per line; a power of two, at least 2.
REQ-004 Parameter LINES, default 16, number of lines; a power of two, at least 2; derived OFF_W=log2(LINE_WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-OFF_W-IDX_W (at least 1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rd_en  input  1  fetch request.
REQ-008 addr  input  ADDR_W  fetch address; offset=addr[OFF_W-1:0], index=next IDX_W bits, tag=top TAG_W bits.
REQ-009 flush  input  1  invalidate all lines.
REQ-010 rd_rdy  output  1  registered one-cycle pulse; inst is valid in that cycle.
REQ-011 inst  output  INST_W  returned instruction; holds its last value when rd_rdy=0.
REQ-012 busy  output  1  high while in state MISS.
REQ-013 mem_rd_en  output  1  line fetch request to memory.
REQ-014 mem_addr  output  ADDR_W-OFF_W  line address, equal to addr[ADDR_W-1:OFF_W] of the missing request.
REQ-015 mem_rd_rdy  input  1  memory line valid, one-cycle pulse.
REQ-016 mem_data  input  INST_W*LINE_WORDS  line data; word k = mem_data[k*INST_W +: INST_W].

Function
REQ-017 Organisation SHALL be direct-mapped; each line holds a valid bit, a TAG_W tag and LINE_WORDS words.
REQ-018 FSM SHALL have two states, IDLE and MISS.
REQ-019 IDLE, edge with flush=1: all valid bits cleared; rd_en at the same edge is not accepted; rd_rdy=0 next cycle.
REQ-020 IDLE, edge with rd_en=1 and flush=0: request accepted; lookup is combinational on addr.
REQ-021 Hit (valid and tag match): at that edge inst<=word[offset] and rd_rdy<=1; hit latency 1 cycle; back-to-back hits give one rd_rdy per cycle.
REQ-022 Miss: at that edge state<=MISS, the request address is latched, mem_rd_en<=1, mem_addr<=line address, rd_rdy<=0.
REQ-023 MISS: mem_rd_en and mem_addr SHALL be held stable until mem_rd_rdy=1 is sampled; rd_en is ignored (not accepted).
REQ-024 MISS, edge with mem_rd_rdy=1: line written with valid=1 and the latched tag; inst<=mem_data word[latched offset] (bypass); rd_rdy<=1; mem_rd_en<=0; state<=IDLE.
REQ-025 Minimum miss latency SHALL be 2 cycles from the accepting edge to rd_rdy.
REQ-026 Flush in MISS: all valid bits cleared; the outstanding fill still completes and its line is valid afterwards.
REQ-027 Flush and mem_rd_rdy at the same edge: the filled line is valid; all other lines are invalid.
REQ-028 mem_rd_rdy sampled in IDLE SHALL be ignored.
REQ-029 A refill to an index SHALL overwrite any line previously held there (conflict eviction).

Reset
REQ-030 While rst=0, without waiting for a clock edge: state=IDLE, all valid bits=0, rd_rdy=0, inst=0, busy=0, mem_rd_en=0, mem_addr=0.
REQ-031 Reset during MISS SHALL abandon the fill; a later mem_rd_rdy produces no rd_rdy and writes no line.
REQ-032 Tag and data arrays need not be reset.

Configuration
REQ-033 Macro ICACHE_STATS_EN defined: outputs hit_cnt and miss_cnt, each 16 bits; +1 per accepted hit or per accepted miss; saturate at 16'hFFFF; cleared by reset only, not by flush.
REQ-034 Macro ICACHE_STATS_EN undefined: hit_cnt and miss_cnt ports and their counters are absent; all other behaviour is identical.

Verification (default parameters)
REQ-035 Cold miss: rd_en=1, addr=0x00 -> mem_rd_en=1, mem_addr=0x00; mem_rd_rdy pulse with mem_data=64'hAAAABBBBCCCCDDDD -> rd_rdy pulse, inst=16'hDDDD.
REQ-036 Sequential hits: addr 0x01, 0x02, 0x03 on consecutive cycles -> inst 16'hCCCC, 16'hBBBB, 16'hAAAA on consecutive cycles; mem_rd_en stays 0.
REQ-037 Conflict: addr 0x40 -> miss with mem_addr=0x10; after that fill, addr 0x00 -> miss again with mem_addr=0x00.
REQ-038 Flush: after the REQ-035 fill, pulse flush, then addr 0x01 -> miss (mem_rd_en=1).
REQ-039 Reset mid-miss: rst=0 while mem_rd_en=1 -> mem_rd_en=0 immediately; after rst=1, a mem_rd_rdy pulse -> no rd_rdy, and addr 0x00 still misses.
REQ-040 Stats, with ICACHE_STATS_EN defined: REQ-035 then REQ-036 -> hit_cnt=3, miss_cnt=1; flush leaves both counts unchanged.
